// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush/freeze sequencer with EX forwarding,
// data-miss watchdog and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int TMO_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memRead,
    input  logic             ex_pcSrc,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regWrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regWrite,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_flush,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [1:0]       state_o,
    output logic             error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN = 2'd0, DMISS = 2'd1, ERR = 2'd2} state_t;

    state_t           r_state, w_next;
    logic [TMO_W-1:0] r_wd, w_wd_next;
    logic             r_error;
    logic [CNT_W-1:0] r_stall, r_flush;
    logic             w_miss, w_load_use, w_branch, w_freeze;

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (mem_regWrite && mem_rd != '0 && mem_rd == src) return 2'b10;
        if (wb_regWrite && wb_rd != '0 && wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        w_miss     = dmem_req && !dmem_ready;
        w_load_use = ex_memRead && ex_rd != '0 &&
                     (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        w_next     = r_state;
        w_wd_next  = r_wd;
        w_branch   = 1'b0;
        w_freeze   = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_flush = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_miss) begin
                    w_freeze  = 1'b1;
                    w_next    = DMISS;
                    w_wd_next = TMO_W'(1);
                end else if (ex_pcSrc) begin
                    w_branch    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (w_load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            DMISS: begin
                if (dmem_ready) begin
                    w_next    = RUN;
                    w_wd_next = '0;
                end else begin
                    w_freeze  = 1'b1;
                    w_next    = &r_wd ? ERR : DMISS;
                    w_wd_next = &r_wd ? r_wd : r_wd + TMO_W'(1);
                end
            end
            default: w_freeze = 1'b1;
        endcase
        // A freeze holds every upstream register and drains MEM/WB with a bubble.
        if (w_freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end
        forward_a = fwd_sel(ex_rs);
        forward_b = fwd_sel(ex_rt);
        if (!reset_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b0;
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
            forward_a    = 2'b00;
            forward_b    = 2'b00;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
            r_wd    <= '0;
            r_error <= 1'b0;
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            r_state <= w_next;
            r_wd    <= w_wd_next;
            if (w_next == ERR) r_error <= 1'b1;
            if (!pc_write && r_state != ERR && !(&r_stall)) r_stall <= r_stall + CNT_W'(1);
            if (w_branch && !(&r_flush)) r_flush <= r_flush + CNT_W'(1);
        end
    end

    assign state_o   = r_state;
    assign error     = r_error;
    assign stall_cnt = r_stall;
    assign flush_cnt = r_flush;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus random traffic against a
// cycle-level behavioural model of the hazard controller.
module tb_pipe_hazard_ctrl;
    localparam int REG_W = 5;
    localparam int TMO_W = 3;
    localparam int CNT_W = 5;
    localparam int WMAX  = (1 << TMO_W) - 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic id_uses_rt, ex_memRead, ex_pcSrc, mem_regWrite, wb_regWrite, dmem_req, dmem_ready;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush;
    logic [1:0] forward_a, forward_b, state_o;
    logic error;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int passed = 0;

    // model state: 0 running, 1 waiting on memory, 2 dead
    int m_state = 0, m_wait = 0, m_err = 0, m_stall = 0, m_flush = 0;
    int n_state = 0, n_wait = 0, n_err = 0, n_stall = 0, n_flush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(REG_W), .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
        .clock(clk), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_memRead(ex_memRead), .ex_pcSrc(ex_pcSrc),
        .mem_rd(mem_rd), .mem_regWrite(mem_regWrite),
        .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .ex_mem_write(ex_mem_write), .mem_wb_flush(mem_wb_flush),
        .forward_a(forward_a), .forward_b(forward_b), .state_o(state_o),
        .error(error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    function automatic int fwd(input logic [REG_W-1:0] s);
        if (mem_regWrite && mem_rd != 0 && mem_rd == s) return 2;
        if (wb_regWrite && wb_rd != 0 && wb_rd == s) return 1;
        return 0;
    endfunction

    // {pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_f}
    // modes: 0 reset, 1 freeze, 2 branch, 3 load-use bubble, 4 normal
    logic [6:0] tbl [5] = '{7'b0010101, 7'b0000001, 7'b1111110, 7'b0001110, 7'b1101010};

    always @(negedge clk) begin
        int mode;
        logic lu;
        lu = ex_memRead && ex_rd != 0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        if (!reset_n) mode = 0;
        else if (m_state == 2 || (m_state == 1 && !dmem_ready) ||
                 (m_state == 0 && dmem_req && !dmem_ready)) mode = 1;
        else if (m_state == 0 && ex_pcSrc) mode = 2;
        else if (m_state == 0 && lu) mode = 3;
        else mode = 4;
        chk("ctrl", {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush}, tbl[mode]);
        chk("fwd_a", forward_a, reset_n ? fwd(ex_rs) : 0);
        chk("fwd_b", forward_b, reset_n ? fwd(ex_rt) : 0);
        chk("state", state_o, reset_n ? m_state : 0);
        chk("error", error, reset_n ? m_err : 0);
        chk("stall_cnt", stall_cnt, reset_n ? m_stall : 0);
        chk("flush_cnt", flush_cnt, reset_n ? m_flush : 0);
        n_state = 0; n_wait = 0; n_err = 0; n_stall = 0; n_flush = 0;
        if (reset_n) begin
            n_state = m_state; n_wait = m_wait; n_err = m_err;
            n_stall = (tbl[mode][6] == 1'b0 && m_state != 2 && m_stall < CMAX) ? m_stall + 1 : m_stall;
            n_flush = (mode == 2 && m_flush < CMAX) ? m_flush + 1 : m_flush;
            if (m_state == 0 && mode == 1) begin
                n_state = 1; n_wait = 0;
            end else if (m_state == 1 && dmem_ready) begin
                n_state = 0; n_wait = 0;
            end else if (m_state == 1) begin
                if (m_wait + 1 == WMAX) begin n_state = 2; n_err = 1; end
                else n_wait = m_wait + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            m_state = 0; m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_state = n_state; m_wait = n_wait; m_err = n_err; m_stall = n_stall; m_flush = n_flush;
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
        ex_memRead = 0; ex_pcSrc = 0; mem_rd = 0; mem_regWrite = 0;
        wb_rd = 0; wb_regWrite = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    initial begin
        idle();
        repeat (2) go();
        chk("rst_pc", pc_write, 0);
        chk("rst_iff", if_id_flush, 1);
        reset_n = 1;
        go();
        ex_memRead = 1; ex_rd = 5; id_rs = 5; #2;
        chk("lu_pc", pc_write, 0);
        chk("lu_idf", id_ex_flush, 1);
        go(); idle(); #2;
        chk("lu_cnt", stall_cnt, 1);
        chk("lu_once", pc_write, 1);
        go(); ex_memRead = 1; ex_rd = 0; id_rs = 0; #2;
        chk("lu_r0", pc_write, 1);
        go(); ex_pcSrc = 1; ex_memRead = 1; ex_rd = 5; id_rs = 5; #2;
        chk("br_pc", pc_write, 1);
        chk("br_iff", if_id_flush, 1);
        chk("br_idf", id_ex_flush, 1);
        go(); idle(); #2;
        chk("br_cnt", flush_cnt, 1);
        chk("br_stall", stall_cnt, 1);
        go(); dmem_req = 1; ex_pcSrc = 1; #2;
        chk("miss_pc", pc_write, 0);
        chk("miss_iff", if_id_flush, 0);
        chk("miss_mwb", mem_wb_flush, 1);
        repeat (3) begin
            go(); #2;
            chk("dm_state", state_o, 1);
            chk("dm_iff", if_id_flush, 0);
        end
        go(); dmem_ready = 1; #2;
        chk("rel_pc", pc_write, 1);
        chk("rel_mwb", mem_wb_flush, 0);
        chk("rel_iff", if_id_flush, 0);
        go(); dmem_req = 0; dmem_ready = 0; #2;
        chk("rel_state", state_o, 0);
        chk("miss_stall", stall_cnt, 5);
        chk("rebr_iff", if_id_flush, 1);
        go(); idle(); #2;
        chk("rebr_cnt", flush_cnt, 2);
        mem_rd = 7; wb_rd = 7; mem_regWrite = 1; wb_regWrite = 1; ex_rs = 7; #2;
        chk("fwd_mem", forward_a, 2);
        go(); mem_regWrite = 0; #2;
        chk("fwd_wb", forward_a, 1);
        go(); mem_regWrite = 1; mem_rd = 0; ex_rt = 0; #2;
        chk("fwd_r0", forward_b, 0);
        go(); idle(); dmem_req = 1;
        go(); #2;
        chk("as_pre", state_o, 1);
        reset_n = 0; #1;
        chk("as_pc", pc_write, 0);
        chk("as_iff", if_id_flush, 1);
        chk("as_state", state_o, 0);
        chk("as_stall", stall_cnt, 0);
        go(); go(); reset_n = 1; idle(); #2;
        chk("as_rel", state_o, 0);
        chk("as_rel_pc", pc_write, 1);
        go(); dmem_req = 1;
        go();
        repeat (6) go();
        #2;
        chk("wd_pre", state_o, 1);
        chk("wd_pre_err", error, 0);
        go(); #2;
        chk("wd_state", state_o, 2);
        chk("wd_err", error, 1);
        dmem_ready = 1;
        go(); go(); #2;
        chk("err_sticky", error, 1);
        chk("err_state", state_o, 2);
        chk("err_pc", pc_write, 0);
        reset_n = 0; #1;
        chk("err_clr", error, 0);
        go(); reset_n = 1; idle();
        go(); ex_memRead = 1; ex_rd = 3; id_rs = 3;
        repeat (40) go();
        #2;
        chk("sat_stall", stall_cnt, CMAX);
        idle(); ex_pcSrc = 1;
        repeat (40) go();
        #2;
        chk("sat_flush", flush_cnt, CMAX);
        reset_n = 0; idle();
        go(); reset_n = 1;
        repeat (3000) begin
            go();
            reset_n      = ($urandom_range(0, 299) != 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rs        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            mem_rd       = 5'($urandom_range(0, 3));
            wb_rd        = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_memRead   = 1'($urandom_range(0, 1));
            ex_pcSrc     = ($urandom_range(0, 3) == 0);
            mem_regWrite = 1'($urandom_range(0, 1));
            wb_regWrite  = 1'($urandom_range(0, 1));
            dmem_req     = ($urandom_range(0, 2) == 0);
            dmem_ready   = ($urandom_range(0, 9) < 7);
        end
        go(); reset_n = 1; idle();
        go(); go();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
